dmi_arbiter: RTL and testbench
==============================

Name: dmi_arbiter

Overview:
- Shares one core-side DMI request/response port between NrReq debug transports, e.g. the JTAG CDC output and a second in-SoC debug master.
- Sits in the clk_i domain between the transports' clock-domain crossings and the debug module's DMI slave.
- Grants one requester at a time, round-robin, with exactly one transaction outstanding.
- Routes each DMI response back to the requester that issued the request.

Parameters:
- NrReq, 2, number of requesters; must be >= 2.
- IdxW, $clog2(NrReq), width of the owner index; derived, not overridden.
- TimeoutCycles, 1024, response watchdog limit; used only with DMI_ARB_TIMEOUT_EN; must be >= 2.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  NrReq x dm::dmi_req_t  per-requester DMI request.
- req_valid_i  in  NrReq  per-requester request valid.
- req_ready_o  out  NrReq  per-requester request accepted.
- resp_o  out  NrReq x dm::dmi_resp_t  per-requester response.
- resp_valid_o  out  NrReq  per-requester response valid.
- resp_ready_i  in  NrReq  per-requester response ready.
- dmi_req_o  out  dm::dmi_req_t  downstream request, registered.
- dmi_req_valid_o  out  1  downstream request valid.
- dmi_req_ready_i  in  1  downstream request ready.
- dmi_resp_i  in  dm::dmi_resp_t  downstream response.
- dmi_resp_valid_i  in  1  downstream response valid.
- dmi_resp_ready_o  out  1  downstream response ready.
- busy_o  out  1  high while state != IDLE.
- owner_o  out  IdxW  index of the current or last granted requester.

Behaviour:
- Reset values:
  - state = IDLE, owner = 0, priority pointer = 0.
  - dmi_req_o = '0; all valid/ready outputs 0 except req_ready_o as defined by the IDLE grant rule; busy_o = 0; resp_o = '0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Winner = first i with req_valid_i[i], searching from the priority pointer upward and wrapping modulo NrReq.
  - req_ready_o[winner] = 1 combinationally; all other req_ready_o = 0.
  - On handshake: register req_i[winner] into dmi_req_o, owner <= winner, go to REQ.
  - No valid request: stay in IDLE.
- REQ:
  - dmi_req_valid_o = 1; dmi_req_o is held stable.
  - On dmi_req_ready_i: go to RESP.
  - req_ready_o = 0 for all requesters.
- RESP (response path is combinational):
  - resp_o[owner] = dmi_resp_i; resp_valid_o[owner] = dmi_resp_valid_i.
  - dmi_resp_ready_o = resp_ready_i[owner].
  - Non-owner resp_valid_o = 0 and resp_o = '0.
  - On the downstream response handshake: priority pointer <= (owner+1) mod NrReq, go to IDLE.
- Latency:
  - Requester handshake in cycle N gives dmi_req_valid_o in cycle N+1.
  - Downstream ready in cycle N+1 allows the response no earlier than cycle N+2.
  - Back-to-back grants: next requester handshake possible the cycle after the response handshake.
- Boundary cases:
  - All requesters valid simultaneously: strict rotation, no starvation; each requester waits at most NrReq-1 transactions.
  - Requester drops req_valid_i while not granted: legal, no state change.
  - dmi_resp_valid_i outside RESP: ignored (dmi_resp_ready_o = 0).
  - Owner holds resp_ready_i low: the response back-pressures the downstream port; no timeout in the base build.
- Reset mid-operation: asserting rst_ni returns to IDLE immediately and the outstanding transaction is abandoned. Upstream reset sequencing (CDC clear) owns recovery.

Optional Feature:
- Macro: DMI_ARB_TIMEOUT_EN.
- Enabled, watchdog:
  - Counter clears on entry to RESP and increments each RESP cycle without dmi_resp_valid_i.
  - When the counter reaches TimeoutCycles-1: present resp_o[owner] = {data: 0, resp: DTM_ERR (2)} with resp_valid_o[owner] = 1.
  - On owner handshake: set the sticky stale flag, rotate the priority pointer, go to IDLE.
  - While stale is set: dmi_resp_ready_o = 1 and the next downstream response is silently consumed, clearing stale. That response never reaches any requester. Grants continue normally.
- Disabled: no counter, no stale flag, no error injection; RESP waits indefinitely.

Decomposition:
- dm package gains:
  - localparam DmiArbTimeoutDefault = 1024.
  - Enum dmi_arb_state_e {ArbIdle, ArbReq, ArbResp}.
  - Existing dmi_req_t/dmi_resp_t and the DTM_ERR encoding are reused unchanged.
- Sub-module dmi_rr_select (combinational): valid vector + priority pointer -> one-hot grant + index. Separated for reuse and standalone unit checks.

Test Plan:
- Single request: req_valid_i = 2'b01, addr = 0x10, op = read.
  - -> dmi_req_valid_o next cycle with addr 0x10.
  - Response data 0xDEADBEEF returns only on resp_valid_o[0]; owner_o = 0.
- Contention: both requesters valid continuously, 4 transactions.
  - -> grant order 0,1,0,1; owner_o follows it.
  - resp_valid_o[1] never asserts during requester-0 transactions.
- Back-pressure: dmi_req_ready_i low 5 cycles, then resp_ready_i[owner] low 3 cycles.
  - -> dmi_req_o stable throughout; dmi_resp_ready_o = 0 for those 3 cycles; no new grant until the response handshake.
- Reset mid-RESP: rst_ni pulsed low while busy_o = 1.
  - -> busy_o = 0 and dmi_req_valid_o = 0 immediately.
  - Next request granted to requester 0.
- Timeout (DMI_ARB_TIMEOUT_EN, TimeoutCycles = 8): downstream silent.
  - -> owner receives resp = 2, data = 0 at RESP cycle 8.
  - The late response with data 0x1234 is consumed and not forwarded; the following transaction completes normally.
- Stray response: dmi_resp_valid_i pulsed while IDLE.
  - -> dmi_resp_ready_o = 0; no resp_valid_o asserts.

Source files
------------

// File: rtl/dmi_arbiter_pkg.sv
// DMI transport types (package dm) and round-robin helpers for the DMI arbiter
// (package dmi_arbiter_pkg). Optional watchdog in the arbiter: DMI_ARB_TIMEOUT_EN.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    // Response code returned to a requester whose transaction was abandoned.
    localparam logic [1:0] DTM_ERR = 2'h2;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    localparam int unsigned DmiArbTimeoutDefault = 1024;

    typedef enum logic [1:0] {
        ArbIdle,
        ArbReq,
        ArbResp
    } dmi_arb_state_e;

endpackage

package dmi_arbiter_pkg;

    // Next index in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dmi_arbiter_rr_select.sv
// Round-robin selector: first valid requester at or above the priority pointer,
// wrapping modulo NrReq. Purely combinational.
module dmi_rr_select #(
    parameter int unsigned NrReq = 2,
    parameter int unsigned IdxW  = $clog2(NrReq)
) (
    input  logic [NrReq-1:0] i_valid,
    input  logic [IdxW-1:0]  i_ptr,
    output logic [NrReq-1:0] o_gnt,
    output logic [IdxW-1:0]  o_idx,
    output logic             o_any
);

    logic [IdxW:0] w_cand;
    logic          w_found;

    // Walk the ring starting at the pointer and latch the first valid entry.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int unsigned k = 0; k < NrReq; k++) begin
            w_cand = {1'b0, i_ptr} + (IdxW+1)'(k);
            if (w_cand >= (IdxW+1)'(NrReq)) begin
                w_cand = w_cand - (IdxW+1)'(NrReq);
            end
            if (!w_found && i_valid[w_cand[IdxW-1:0]]) begin
                w_found                   = 1'b1;
                o_idx                     = w_cand[IdxW-1:0];
                o_gnt[w_cand[IdxW-1:0]]   = 1'b1;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/dmi_arbiter.sv
// DMI arbiter: shares one downstream DMI port between NrReq debug transports,
// round-robin, one transaction outstanding, responses routed to the issuer.
// Optional response watchdog with stale-response discard: DMI_ARB_TIMEOUT_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ArbIdle | no transaction; winner of the ring sees req_ready_o
//   ArbReq  | registered request presented downstream, awaiting ready
//   ArbResp | awaiting downstream response, forwarded to the owner
module dmi_arbiter
    import dmi_arbiter_pkg::*;
#(
    parameter int unsigned NrReq         = 2,
    parameter int unsigned IdxW          = $clog2(NrReq),
    parameter int unsigned TimeoutCycles = dm::DmiArbTimeoutDefault
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  dm::dmi_req_t  [NrReq-1:0]   req_i,
    input  logic          [NrReq-1:0]   req_valid_i,
    output logic          [NrReq-1:0]   req_ready_o,
    output dm::dmi_resp_t [NrReq-1:0]   resp_o,
    output logic          [NrReq-1:0]   resp_valid_o,
    input  logic          [NrReq-1:0]   resp_ready_i,
    output dm::dmi_req_t                dmi_req_o,
    output logic                        dmi_req_valid_o,
    input  logic                        dmi_req_ready_i,
    input  dm::dmi_resp_t               dmi_resp_i,
    input  logic                        dmi_resp_valid_i,
    output logic                        dmi_resp_ready_o,
    output logic                        busy_o,
    output logic          [IdxW-1:0]    owner_o
);

    if (NrReq < 2) begin : g_chk_nrreq
        $error("dmi_arbiter: NrReq must be >= 2");
    end
    if (TimeoutCycles < 2) begin : g_chk_timeout
        $error("dmi_arbiter: TimeoutCycles must be >= 2");
    end

    dm::dmi_arb_state_e r_state;
    dm::dmi_arb_state_e w_state_next;
    logic [IdxW-1:0]    r_owner;
    logic [IdxW-1:0]    r_ptr;
    dm::dmi_req_t       r_dmi_req;
    logic [NrReq-1:0]   w_win_gnt;
    logic [IdxW-1:0]    w_win_idx;
    logic               w_win_any;
    logic               w_owner_ready;
    logic               w_resp_done;

    dmi_rr_select #(
        .NrReq (NrReq),
        .IdxW  (IdxW)
    ) u_rr_select (
        .i_valid (req_valid_i),
        .i_ptr   (r_ptr),
        .o_gnt   (w_win_gnt),
        .o_idx   (w_win_idx),
        .o_any   (w_win_any)
    );

    assign w_owner_ready = resp_ready_i[r_owner];

`ifdef DMI_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles);

    logic [CntW-1:0] r_wd_cnt;
    logic            r_stale;
    logic            w_timeout;

    assign w_timeout   = (r_state == dm::ArbResp) && (r_wd_cnt == CntW'(TimeoutCycles - 1));
    // A response arriving while stale belongs to the abandoned transaction.
    assign w_resp_done = (r_state == dm::ArbResp) &&
                         (w_timeout ? w_owner_ready
                                    : (!r_stale && dmi_resp_valid_i && w_owner_ready));

    // Watchdog counter and stale-response flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wd_cnt <= '0;
            r_stale  <= 1'b0;
        end else begin
            if (r_state == dm::ArbReq && dmi_req_ready_i) begin
                r_wd_cnt <= '0;
            end else if (r_state == dm::ArbResp && !dmi_resp_valid_i && !w_timeout) begin
                r_wd_cnt <= r_wd_cnt + CntW'(1);
            end
            if (w_timeout && w_owner_ready) begin
                r_stale <= 1'b1;
            end else if (r_stale && dmi_resp_valid_i) begin
                r_stale <= 1'b0;
            end
        end
    end
`else
    assign w_resp_done = (r_state == dm::ArbResp) && dmi_resp_valid_i && w_owner_ready;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= dm::ArbIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            dm::ArbIdle: if (w_win_any)       w_state_next = dm::ArbReq;
            dm::ArbReq:  if (dmi_req_ready_i) w_state_next = dm::ArbResp;
            dm::ArbResp: if (w_resp_done)     w_state_next = dm::ArbIdle;
            default:                          w_state_next = dm::ArbIdle;
        endcase
    end

    // Grant capture, owner tracking and priority rotation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner   <= '0;
            r_ptr     <= '0;
            r_dmi_req <= '0;
        end else begin
            if (r_state == dm::ArbIdle && w_win_any) begin
                r_owner   <= w_win_idx;
                r_dmi_req <= req_i[w_win_idx];
            end
            if (w_resp_done) begin
                r_ptr <= IdxW'(rr_next(32'(r_owner), NrReq));
            end
        end
    end

    // Handshake outputs and combinational response routing.
    always_comb begin
        req_ready_o      = '0;
        dmi_req_valid_o  = 1'b0;
        resp_o           = '0;
        resp_valid_o     = '0;
        dmi_resp_ready_o = 1'b0;
        busy_o           = (r_state != dm::ArbIdle);
        case (r_state)
            dm::ArbIdle: req_ready_o = w_win_gnt;
            dm::ArbReq:  dmi_req_valid_o = 1'b1;
            dm::ArbResp: begin
`ifdef DMI_ARB_TIMEOUT_EN
                if (w_timeout) begin
                    resp_o[r_owner].resp = dm::DTM_ERR;
                    resp_valid_o[r_owner] = 1'b1;
                end else if (!r_stale) begin
                    resp_o[r_owner]       = dmi_resp_i;
                    resp_valid_o[r_owner] = dmi_resp_valid_i;
                    dmi_resp_ready_o      = w_owner_ready;
                end
`else
                resp_o[r_owner]       = dmi_resp_i;
                resp_valid_o[r_owner] = dmi_resp_valid_i;
                dmi_resp_ready_o      = w_owner_ready;
`endif
            end
            default: ;
        endcase
`ifdef DMI_ARB_TIMEOUT_EN
        if (r_stale) begin
            dmi_resp_ready_o = 1'b1;
        end
`endif
    end

    assign dmi_req_o = r_dmi_req;
    assign owner_o   = r_owner;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Self-checking bench for dmi_arbiter (NrReq = 2, TimeoutCycles = 8).
// Watchdog scenario is compiled in when DMI_ARB_TIMEOUT_EN is defined.
module tb_dmi_arbiter;

    localparam int unsigned N = 2;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    dm::dmi_req_t  [N-1:0]  req_i;
    logic          [N-1:0]  req_valid_i;
    logic          [N-1:0]  req_ready_o;
    dm::dmi_resp_t [N-1:0]  resp_o;
    logic          [N-1:0]  resp_valid_o;
    logic          [N-1:0]  resp_ready_i;
    dm::dmi_req_t           dmi_req_o;
    logic                   dmi_req_valid_o;
    logic                   dmi_req_ready_i;
    dm::dmi_resp_t          dmi_resp_i;
    logic                   dmi_resp_valid_i;
    logic                   dmi_resp_ready_o;
    logic                   busy_o;
    logic          [0:0]    owner_o;

    int          errors = 0;
    int          checks = 0;
    int unsigned m_ptr  = 0;

    dmi_arbiter #(
        .NrReq         (N),
        .TimeoutCycles (8)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .req_i            (req_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .resp_o           (resp_o),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .dmi_req_o        (dmi_req_o),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_resp_i       (dmi_resp_i),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .busy_o           (busy_o),
        .owner_o          (owner_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    // Reference rule: first valid requester from the pointer upward, modulo N.
    function automatic int unsigned model_winner(input logic [N-1:0] vld);
        for (int unsigned k = 0; k < N; k++) begin
            if (vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return 0;
    endfunction

    function automatic dm::dmi_req_t rand_req();
        dm::dmi_req_t q;
        q.addr = 7'($urandom);
        q.op   = dm::dtm_op_e'(2'($urandom_range(0, 2)));
        q.data = $urandom;
        return q;
    endfunction

    // One complete transaction from IDLE back to IDLE, checked at every stage.
    task automatic run_txn(input logic [N-1:0] vld, input dm::dmi_req_t q0, input dm::dmi_req_t q1,
                           input int unsigned req_wait, input int unsigned resp_wait,
                           input int unsigned bp_wait, input logic [31:0] rdata, input logic [1:0] rcode);
        int unsigned   w;
        int unsigned   o;
        logic [N-1:0]  w_hot;
        logic [N-1:0]  others;
        logic [N-1:0]  b2b;
        dm::dmi_req_t  exp_q;
        dm::dmi_resp_t exp_r;
        w      = model_winner(vld);
        o      = (w == 0) ? 1 : 0;
        w_hot  = N'(1) << w;
        others = vld & ~w_hot;
        exp_q  = (w == 0) ? q0 : q1;
        exp_r.data = rdata;
        exp_r.resp = rcode;
        req_i[0] = q0;
        req_i[1] = q1;
        req_valid_i  = vld;
        resp_ready_i = '1;
        #1;
        chk("idle_grant", 64'(req_ready_o), 64'(w_hot));
        chk("idle_busy", 64'(busy_o), 64'(0));
        tick();
        req_valid_i = others;
        #1;
        chk("req_valid", 64'(dmi_req_valid_o), 64'(1));
        chk("req_data", 64'(dmi_req_o), 64'(exp_q));
        chk("owner", 64'(owner_o), 64'(w));
        chk("req_no_grant", 64'(req_ready_o), 64'(0));
        for (int unsigned k = 0; k < req_wait; k++) begin
            tick();
            #1;
            chk("req_hold_data", 64'(dmi_req_o), 64'(exp_q));
            chk("req_hold_valid", 64'(dmi_req_valid_o), 64'(1));
            chk("req_hold_grant", 64'(req_ready_o), 64'(0));
        end
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        #1;
        chk("resp_req_valid", 64'(dmi_req_valid_o), 64'(0));
        chk("resp_busy", 64'(busy_o), 64'(1));
        chk("resp_early_valid", 64'(resp_valid_o), 64'(0));
        for (int unsigned k = 0; k < resp_wait; k++) begin
            tick();
            #1;
            chk("resp_wait_valid", 64'(resp_valid_o), 64'(0));
            chk("resp_wait_dready", 64'(dmi_resp_ready_o), 64'(1));
        end
        dmi_resp_i       = exp_r;
        dmi_resp_valid_i = 1'b1;
        resp_ready_i     = (bp_wait > 0) ? ~w_hot : '1;
        for (int unsigned k = 0; k < bp_wait; k++) begin
            #1;
            chk("bp_dready", 64'(dmi_resp_ready_o), 64'(0));
            chk("bp_valid", 64'(resp_valid_o), 64'(w_hot));
            chk("bp_data", 64'(resp_o[w]), 64'(exp_r));
            chk("bp_grant", 64'(req_ready_o), 64'(0));
            chk("bp_req_data", 64'(dmi_req_o), 64'(exp_q));
            tick();
        end
        resp_ready_i = '1;
        #1;
        chk("resp_valid", 64'(resp_valid_o), 64'(w_hot));
        chk("resp_data", 64'(resp_o[w]), 64'(exp_r));
        chk("resp_other", 64'(resp_o[o]), 64'(0));
        chk("resp_dready", 64'(dmi_resp_ready_o), 64'(1));
        tick();
        dmi_resp_valid_i = 1'b0;
        dmi_resp_i       = '0;
        m_ptr            = (w + 1) % N;
        b2b              = (others != 0) ? (N'(1) << model_winner(others)) : '0;
        #1;
        chk("done_busy", 64'(busy_o), 64'(0));
        chk("done_valid", 64'(resp_valid_o), 64'(0));
        chk("b2b_grant", 64'(req_ready_o), 64'(b2b));
        req_valid_i = '0;
    endtask

    initial begin
        int unsigned order [4] = '{0, 1, 0, 1};
        dm::dmi_req_t q0;
        dm::dmi_req_t q1;

        rst_ni           = 1'b0;
        req_i            = '0;
        req_valid_i      = '0;
        resp_ready_i     = '0;
        dmi_req_ready_i  = 1'b0;
        dmi_resp_i       = '0;
        dmi_resp_valid_i = 1'b0;
        #1;
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_owner", 64'(owner_o), 64'(0));
        chk("rst_req_valid", 64'(dmi_req_valid_o), 64'(0));
        chk("rst_req_data", 64'(dmi_req_o), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid_o), 64'(0));
        chk("rst_resp_data", 64'(resp_o), 64'(0));
        chk("rst_dready", 64'(dmi_resp_ready_o), 64'(0));
        chk("rst_grant", 64'(req_ready_o), 64'(0));
        tick();
        tick();
        rst_ni = 1'b1;

        // Single read from requester 0.
        q0 = '0;
        q0.addr = 7'h10;
        q0.op   = dm::DTM_READ;
        q1 = rand_req();
        run_txn(2'b01, q0, q1, 0, 0, 0, 32'hDEADBEEF, 2'd0);
        chk("single_owner", 64'(owner_o), 64'(0));

        // Reset while a response from requester 1 is being presented.
        req_i[1]    = rand_req();
        req_valid_i = 2'b10;
        #1;
        chk("prerst_grant", 64'(req_ready_o), 64'(2'b10));
        tick();
        req_valid_i     = '0;
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i  = 1'b0;
        dmi_resp_i.data  = 32'hCAFE0001;
        dmi_resp_i.resp  = 2'd0;
        dmi_resp_valid_i = 1'b1;
        resp_ready_i     = '1;
        #1;
        chk("prerst_busy", 64'(busy_o), 64'(1));
        chk("prerst_resp_valid", 64'(resp_valid_o), 64'(2'b10));
        rst_ni = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy_o), 64'(0));
        chk("midrst_req_valid", 64'(dmi_req_valid_o), 64'(0));
        chk("midrst_resp_valid", 64'(resp_valid_o), 64'(0));
        chk("midrst_owner", 64'(owner_o), 64'(0));
        chk("midrst_dready", 64'(dmi_resp_ready_o), 64'(0));
        dmi_resp_valid_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        m_ptr  = 0;

        // Contention: both requesters always valid, strict rotation from 0.
        for (int unsigned k = 0; k < 4; k++) begin
            run_txn(2'b11, rand_req(), rand_req(), 1, 1, 1, $urandom, 2'd0);
            chk("cont_order", 64'(owner_o), 64'(order[k]));
        end

        // Back-pressure on both downstream request and owner response.
        run_txn(2'b11, rand_req(), rand_req(), 5, 0, 3, 32'h0BADF00D, 2'd0);

        // Randomised transactions against the round-robin model.
        for (int unsigned k = 0; k < 20; k++) begin
            run_txn(N'($urandom_range(1, 3)), rand_req(), rand_req(),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom, 2'($urandom));
        end

        // Stray downstream response while idle.
        req_valid_i      = '0;
        resp_ready_i     = '1;
        dmi_resp_i.data  = 32'h55AA55AA;
        dmi_resp_i.resp  = 2'd0;
        dmi_resp_valid_i = 1'b1;
        #1;
        chk("stray_dready", 64'(dmi_resp_ready_o), 64'(0));
        chk("stray_valid", 64'(resp_valid_o), 64'(0));
        tick();
        #1;
        chk("stray_busy", 64'(busy_o), 64'(0));
        chk("stray_valid2", 64'(resp_valid_o), 64'(0));
        dmi_resp_valid_i = 1'b0;
        dmi_resp_i       = '0;

`ifdef DMI_ARB_TIMEOUT_EN
        // Downstream silent: error injected at RESP cycle 8, late response discarded.
        req_i[0]     = rand_req();
        req_valid_i  = 2'b01;
        resp_ready_i = '1;
        tick();
        req_valid_i     = '0;
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        for (int unsigned c = 1; c < 8; c++) begin
            #1;
            chk("wd_quiet", 64'(resp_valid_o), 64'(0));
            tick();
        end
        #1;
        chk("wd_valid", 64'(resp_valid_o), 64'(2'b01));
        chk("wd_resp", 64'(resp_o[0]), 64'({32'h0, 2'd2}));
        chk("wd_dready", 64'(dmi_resp_ready_o), 64'(0));
        tick();
        m_ptr = 1;
        #1;
        chk("wd_busy", 64'(busy_o), 64'(0));
        chk("stale_dready", 64'(dmi_resp_ready_o), 64'(1));
        dmi_resp_i.data  = 32'h1234;
        dmi_resp_i.resp  = 2'd0;
        dmi_resp_valid_i = 1'b1;
        #1;
        chk("stale_no_fwd", 64'(resp_valid_o), 64'(0));
        tick();
        dmi_resp_valid_i = 1'b0;
        dmi_resp_i       = '0;
        #1;
        chk("stale_cleared", 64'(dmi_resp_ready_o), 64'(0));
        chk("stale_no_fwd2", 64'(resp_valid_o), 64'(0));
        run_txn(2'b01, rand_req(), rand_req(), 1, 2, 1, 32'h600DCAFE, 2'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
